// File: rtl/split_pulse_scheduler_if.sv
// ============================================================================
// Module      : split_pulse_scheduler_if
// Description : Requester/observer bundle of the SPLIT-cell pulse scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface split_pulse_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
);
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic             a_out;
  logic             busy;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output req,
    input  gnt, a_out, busy, issue_cnt, stall_cnt
  );

  modport slave (
    input  req,
    output gnt, a_out, busy, issue_cnt, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/split_pulse_scheduler.sv
// ============================================================================
// Module      : split_pulse_scheduler
// Description : Round-robin scheduler driving one toggle-encoded SPLIT input,
//               with start-up holdoff and post-pulse recovery gap.
//               Optional statistics counters: define SPLIT_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module split_pulse_scheduler #(
  parameter int NREQ         = 4,
  parameter int GAP_CYCLES   = 7,
  parameter int BEGIN_CYCLES = 8,
  parameter int CNT_W        = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  split_pulse_scheduler_if.slave bus
);

  localparam int MAXC = (GAP_CYCLES > BEGIN_CYCLES) ? GAP_CYCLES : BEGIN_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_INIT    = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic            r_a;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_next_ptr;
  logic [NREQ-1:0] w_onehot;

  // First requester at or above the round-robin pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = int'(r_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && bus.req[j]) begin
        w_found = 1'b1;
        w_win   = PW'(j);
      end
    end
  end

  assign w_next_ptr = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
  assign w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_cnt   <= CW'(BEGIN_CYCLES);
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_a     <= 1'b0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        S_INIT: begin
          if (r_cnt == CW'(1)) r_state <= S_IDLE;
          else                 r_cnt   <= r_cnt - CW'(1);
        end
        S_IDLE: begin
          if (w_found) begin
            r_gnt <= w_onehot;
            r_a   <= ~r_a;
            r_ptr <= w_next_ptr;
            // With no gap the scheduler can grant back-to-back from IDLE.
            if (GAP_CYCLES > 0) begin
              r_state <= S_RECOVER;
              r_cnt   <= CW'(GAP_CYCLES);
            end
          end
        end
        S_RECOVER: begin
          if (r_cnt == CW'(1)) r_state <= S_IDLE;
          else                 r_cnt   <= r_cnt - CW'(1);
        end
        default: begin
          r_state <= S_INIT;
          r_cnt   <= CW'(BEGIN_CYCLES);
        end
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.a_out = r_a;
  assign bus.busy  = (r_state != S_IDLE);

`ifdef SPLIT_SCHED_STATS_EN
  logic [CNT_W-1:0] r_issue;
  logic [CNT_W-1:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue <= '0;
      r_stall <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) r_issue <= r_issue + CNT_W'(1);
      // Stall count saturates rather than wraps.
      if (bus.req != '0 && r_state != S_IDLE && r_stall != '1)
        r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign bus.issue_cnt = r_issue;
  assign bus.stall_cnt = r_stall;
`else
  assign bus.issue_cnt = '0;
  assign bus.stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_split_pulse_scheduler.sv
// ============================================================================
// Module      : tb_split_pulse_scheduler
// Description : Self-checking bench for split_pulse_scheduler (two configs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_split_pulse_scheduler;

  localparam int B_BEGIN = 20;
  localparam int B_CNTW  = 4;
`ifdef SPLIT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  split_pulse_scheduler_if #(.NREQ(4), .CNT_W(16))     bus_a ();
  split_pulse_scheduler_if #(.NREQ(4), .CNT_W(B_CNTW)) bus_b ();

  split_pulse_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  split_pulse_scheduler #(
    .NREQ(4), .GAP_CYCLES(0), .BEGIN_CYCLES(B_BEGIN), .CNT_W(B_CNTW)
  ) dut_g0 (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // Reference: "earliest edge a grant may issue" plus a rotating priority.
  typedef struct {
    int         cyc;
    int         next_ok;
    int         ptr;
    logic [3:0] gnt;
    logic       a;
    logic       busy;
    int         issue;
    int         stall;
  } model_t;

  model_t ma, mb;
  int passed = 0;
  int total  = 0;

  function automatic model_t mstep(model_t m, logic r, logic [3:0] rq,
                                   int gap, int beg, int cw);
    int mask;
    mask  = (1 << cw) - 1;
    m.cyc = m.cyc + 1;
    if (r) begin
      m.gnt = '0; m.a = 1'b0; m.busy = 1'b1;
      m.issue = 0; m.stall = 0; m.ptr = 0;
      m.next_ok = m.cyc + beg + 1;
      return m;
    end
    if (STATS && rq != 0 && m.busy && m.stall < mask) m.stall = m.stall + 1;
    m.gnt = '0;
    if (!m.busy && rq != 0) begin
      for (int k = 0; k < 4; k++) begin
        int w;
        w = (m.ptr + k) % 4;
        if (m.gnt == 0 && rq[w]) begin
          m.gnt = 4'(1 << w);
          m.ptr = (w + 1) % 4;
        end
      end
      m.a = ~m.a;
      if (STATS) m.issue = (m.issue + 1) & mask;
      m.next_ok = m.cyc + gap + 1;
    end
    m.busy = (m.cyc + 1 < m.next_ok);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] ra, input logic [3:0] rb);
    rst       = r;
    bus_a.req = ra;
    bus_b.req = rb;
    @(posedge clk);
    ma = mstep(ma, r, ra, 7, 8, 16);
    mb = mstep(mb, r, rb, 0, B_BEGIN, B_CNTW);
    #1;
    chk("a.gnt",   32'(bus_a.gnt),       32'(ma.gnt));
    chk("a.a_out", 32'(bus_a.a_out),     32'(ma.a));
    chk("a.busy",  32'(bus_a.busy),      32'(ma.busy));
    chk("a.issue", 32'(bus_a.issue_cnt), 32'(ma.issue));
    chk("a.stall", 32'(bus_a.stall_cnt), 32'(ma.stall));
    chk("b.gnt",   32'(bus_b.gnt),       32'(mb.gnt));
    chk("b.a_out", 32'(bus_b.a_out),     32'(mb.a));
    chk("b.busy",  32'(bus_b.busy),      32'(mb.busy));
    chk("b.issue", 32'(bus_b.issue_cnt), 32'(mb.issue));
    chk("b.stall", 32'(bus_b.stall_cnt), 32'(mb.stall));
  endtask

  initial begin
    int first_gnt;
    int ngnt;
    int waited;
    ma = '{default: 0};
    mb = '{default: 0};
    bus_a.req = '0;
    bus_b.req = '0;
    #1;

    // Single requester after reset: first grant on the 9th edge after release.
    step(1'b1, 4'b0000, 4'b0000);
    first_gnt = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 4'b0001, 4'b0101);
      if (bus_a.gnt != 0 && first_gnt < 0) first_gnt = k;
    end
    chk("first_grant_edge", 32'(first_gnt), 32'd9);
    if (STATS) chk("b.stall_sat", 32'(bus_b.stall_cnt), 32'd15);

    // Full load: five grants spaced eight cycles apart.
    ngnt = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 4'b1111, 4'($urandom));
      if (bus_a.gnt != 0) ngnt++;
    end
    chk("full_load_grants", 32'(ngnt), 32'd5);

    // Request pulsed for one cycle while recovering.
    waited = 0;
    while (bus_a.gnt == 0 && waited < 20) begin
      step(1'b0, 4'b0100, 4'b0000);
      waited++;
    end
    chk("grant_seen", 32'(bus_a.gnt != 0), 32'd1);
    step(1'b0, 4'b0000, 4'b0000);
    step(1'b0, 4'b0010, 4'b0000);
    for (int k = 0; k < 10; k++) step(1'b0, 4'b0000, 4'b0000);

    // Reset three cycles into recovery.
    waited = 0;
    while (bus_a.gnt == 0 && waited < 20) begin
      step(1'b0, 4'b1000, 4'b0011);
      waited++;
    end
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0000, 4'b0011);
    step(1'b1, 4'b0000, 4'b0011);
    chk("rst_a_out", 32'(bus_a.a_out), 32'd0);
    chk("rst_busy",  32'(bus_a.busy),  32'd1);
    for (int k = 0; k < 30; k++) step(1'b0, 4'b0110, 4'b1001);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 63) == 0), 4'($urandom), 4'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
